// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU-side and memory-side signal bundle of the L1 data cache
interface dcache_controller_if;
  // CPU load/store stage
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_mem_read_i;
  logic         cpu_mem_write_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  // 256-bit line protocol towards Data_Memory
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  // Cache view: serves the CPU and initiates line transfers
  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_mem_read_i, cpu_mem_write_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_ack_i, mem_data_i
  );

  // Environment view: CPU and memory around the cache
  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_mem_read_i, cpu_mem_write_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_ack_i, mem_data_i
  );
endinterface

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache
module dcache_controller #(
  parameter int LINE_COUNT = 32,
  parameter int TAG_W      = 22
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.master bus
);

  localparam int IDX_W = $clog2(LINE_COUNT);
  localparam int OFF_W = 5;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WB_REQ    = 2'd1;
  localparam logic [1:0] FILL_REQ  = 2'd2;
  localparam logic [1:0] FILL_DATA = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LINE_COUNT-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [LINE_COUNT];
  logic [255:0]          line_q [LINE_COUNT];
  logic [31:0]           cpu_data_q;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [2:0]            req_word;
  logic                  req;
  logic                  hit;
  logic                  victim_dirty;
  logic [31:0]           sel_word;
  logic                  read_hit;
  logic                  write_hit;

  logic [31:0]           cpu_data_c;
  logic                  cpu_stall_c;
  logic [31:0]           mem_addr_c;
  logic [255:0]          mem_data_c;
  logic                  mem_enable_c;
  logic                  mem_write_c;

  assign req_tag      = bus.cpu_addr_i[31 -: TAG_W];
  assign req_idx      = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign req_word     = bus.cpu_addr_i[4:2];
  assign req          = bus.cpu_mem_read_i | bus.cpu_mem_write_i;
  assign hit          = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign sel_word     = line_q[req_idx][{req_word, 5'b0} +: 32];
  // Hits are only served in IDLE; array updates are suppressed while reset is held.
  assign read_hit     = (state_q == IDLE) && hit && bus.cpu_mem_read_i && !rst_i;
  assign write_hit    = (state_q == IDLE) && hit && bus.cpu_mem_write_i && !rst_i;

  // Miss sequencing: optional write-back of a dirty victim, then refill, then replay in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req && !hit) state_d = victim_dirty ? WB_REQ : FILL_REQ;
      WB_REQ:    if (bus.mem_ack_i) state_d = FILL_REQ;
      FILL_REQ:  if (bus.mem_ack_i) state_d = FILL_DATA;
      FILL_DATA: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Line status bits: refill makes a line valid and clean, a store hit makes it dirty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == FILL_DATA) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: refill installs the whole line, a store hit merges one word
  always_ff @(posedge clk_i) begin
    if (state_q == FILL_DATA) begin
      line_q[req_idx] <= bus.mem_data_i;
      tag_q[req_idx]  <= req_tag;
    end else if (write_hit) begin
      line_q[req_idx][{req_word, 5'b0} +: 32] <= bus.cpu_data_i;
    end
  end

  // Last load result, so cpu_data_o holds between loads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         cpu_data_q <= '0;
    else if (read_hit) cpu_data_q <= sel_word;
  end

  // Output decode; everything is forced to zero while reset is asserted
  always_comb begin
    cpu_data_c   = '0;
    cpu_stall_c  = 1'b0;
    mem_addr_c   = '0;
    mem_data_c   = '0;
    mem_enable_c = 1'b0;
    mem_write_c  = 1'b0;
    if (!rst_i) begin
      cpu_data_c  = read_hit ? sel_word : cpu_data_q;
      cpu_stall_c = (state_q != IDLE) || (req && !hit);
      case (state_q)
        WB_REQ: begin
          mem_enable_c = 1'b1;
          mem_write_c  = 1'b1;
          mem_addr_c   = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
          mem_data_c   = line_q[req_idx];
        end
        FILL_REQ: begin
          mem_enable_c = 1'b1;
          mem_addr_c   = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_data_o   = cpu_data_c;
  assign bus.cpu_stall_o  = cpu_stall_c;
  assign bus.mem_addr_o   = mem_addr_c;
  assign bus.mem_data_o   = mem_data_c;
  assign bus.mem_enable_o = mem_enable_c;
  assign bus.mem_write_o  = mem_write_c;

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller
module tb_dcache_controller;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  req_t reqs[$];

  logic         mem_ack;
  logic [255:0] mem_rdata;
  logic [255:0] mem_q [0:127];
  logic [3:0]   cnt;
  logic         init_done = 1'b0;

  logic         prev_en, prev_ack, prev_wr;
  logic [31:0]  prev_addr;
  logic [255:0] prev_data;

  dcache_controller_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.mem_ack_i  = mem_ack;
  assign bus.mem_data_i = mem_rdata;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line_pat(input logic [6:0] li);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = {4'hA, 16'h0, li, 3'(w), 2'b00};
    return r;
  endfunction

  // Memory model: ack on the 11th cycle of a request, read data the cycle after ack
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= line_pat(7'(i));
      init_done <= 1'b1;
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      cnt       <= '0;
    end else if (rst) begin
      mem_ack <= 1'b0;
      cnt     <= '0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      if (bus.mem_write_o) mem_q[bus.mem_addr_o[11:5]] <= bus.mem_data_o;
      else                 mem_rdata <= mem_q[bus.mem_addr_o[11:5]];
    end else if (bus.mem_enable_o) begin
      if (cnt == 4'd9) begin
        mem_ack <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Request logger and hold-until-ack checker
  always @(negedge clk) begin
    if (rst) begin
      prev_en  <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      if (bus.mem_enable_o && !(prev_en && !prev_ack))
        reqs.push_back('{bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o});
      if (bus.mem_enable_o && prev_en && !prev_ack) begin
        chk("hold_addr", 256'(bus.mem_addr_o), 256'(prev_addr));
        chk("hold_wr", 256'(bus.mem_write_o), 256'(prev_wr));
        chk("hold_data", bus.mem_data_o, prev_data);
      end
      prev_en   <= bus.mem_enable_o;
      prev_ack  <= mem_ack;
      prev_wr   <= bus.mem_write_o;
      prev_addr <= bus.mem_addr_o;
      prev_data <= bus.mem_data_o;
    end
  end

  // Call at posedge+1; returns stall cycles and the word seen in the first unstalled cycle
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    reqs.delete();
    bus.cpu_addr_i      = addr;
    bus.cpu_data_i      = wdata;
    bus.cpu_mem_read_i  = !wr;
    bus.cpu_mem_write_i = wr;
    stalls = 0;
    rdata  = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) begin
        rdata = bus.cpu_data_o;
        break;
      end
      stalls++;
    end
    @(posedge clk);
    #1;
    bus.cpu_mem_read_i  = 1'b0;
    bus.cpu_mem_write_i = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_data"},   256'(bus.cpu_data_o),   256'(0));
    chk({pfx, "_stall"},  256'(bus.cpu_stall_o),  256'(0));
    chk({pfx, "_en"},     256'(bus.mem_enable_o), 256'(0));
    chk({pfx, "_wr"},     256'(bus.mem_write_o),  256'(0));
    chk({pfx, "_addr"},   256'(bus.mem_addr_o),   256'(0));
    chk({pfx, "_mdata"},  bus.mem_data_o,         256'(0));
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst                 = 1'b1;
    bus.cpu_addr_i      = '0;
    bus.cpu_data_i      = '0;
    bus.cpu_mem_read_i  = 1'b0;
    bus.cpu_mem_write_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;

    // Cold read of line 2
    access(32'h40, 1'b0, '0, st, rd);
    chk("cold_stall", 256'(st), 256'(13));
    chk("cold_nreq", 256'(reqs.size()), 256'(1));
    if (reqs.size() > 0) begin
      chk("cold_wr", 256'(reqs[0].wr), 256'(0));
      chk("cold_addr", 256'(reqs[0].addr), 256'(32'h40));
    end
    chk("cold_data", 256'(rd), 256'(32'hA000_0040));

    access(32'h40, 1'b0, '0, st, rd);
    chk("rehit_stall", 256'(st), 256'(0));
    chk("rehit_data", 256'(rd), 256'(32'hA000_0040));

    // Store hit then load back
    access(32'h44, 1'b1, 32'hDEAD_BEEF, st, rd);
    chk("st_stall", 256'(st), 256'(0));
    chk("st_nreq", 256'(reqs.size()), 256'(0));
    access(32'h44, 1'b0, '0, st, rd);
    chk("ld44_stall", 256'(st), 256'(0));
    chk("ld44_data", 256'(rd), 256'(32'hDEAD_BEEF));

    // No request: output holds
    @(negedge clk);
    chk("idle_hold", 256'(bus.cpu_data_o), 256'(32'hDEAD_BEEF));
    @(posedge clk);
    #1;

    // Dirty eviction of line 2
    access(32'h444, 1'b0, '0, st, rd);
    chk("evict_stall", 256'(st), 256'(24));
    chk("evict_nreq", 256'(reqs.size()), 256'(2));
    if (reqs.size() > 1) begin
      chk("wb_wr", 256'(reqs[0].wr), 256'(1));
      chk("wb_addr", 256'(reqs[0].addr), 256'(32'h40));
      chk("wb_w1", 256'(reqs[0].data[63:32]), 256'(32'hDEAD_BEEF));
      chk("wb_w0", 256'(reqs[0].data[31:0]), 256'(32'hA000_0040));
      chk("fill_wr", 256'(reqs[1].wr), 256'(0));
      chk("fill_addr", 256'(reqs[1].addr), 256'(32'h440));
    end
    chk("evict_data", 256'(rd), 256'(32'hA000_0444));

    // Clean miss back to the written-back line
    access(32'h44, 1'b0, '0, st, rd);
    chk("back_stall", 256'(st), 256'(13));
    chk("back_data", 256'(rd), 256'(32'hDEAD_BEEF));

    // Write miss to clean line 0, then conflicting miss writes it back
    access(32'h800, 1'b1, 32'h1234_5678, st, rd);
    chk("wmiss_stall", 256'(st), 256'(13));
    chk("wmiss_nreq", 256'(reqs.size()), 256'(1));
    access(32'h800, 1'b0, '0, st, rd);
    chk("wmiss_ld", 256'(rd), 256'(32'h1234_5678));
    access(32'h000, 1'b0, '0, st, rd);
    chk("conf_stall", 256'(st), 256'(24));
    chk("conf_nreq", 256'(reqs.size()), 256'(2));
    if (reqs.size() > 1) begin
      chk("conf_wb_addr", 256'(reqs[0].addr), 256'(32'h800));
      chk("conf_wb_w0", 256'(reqs[0].data[31:0]), 256'(32'h1234_5678));
      chk("conf_wb_w1", 256'(reqs[0].data[63:32]), 256'(32'hA000_0804));
      chk("conf_fill_addr", 256'(reqs[1].addr), 256'(32'h0));
    end
    chk("conf_data", 256'(rd), 256'(32'hA000_0000));

    // Reset in the 5th FILL_REQ cycle
    bus.cpu_addr_i     = 32'hC20;
    bus.cpu_mem_read_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_en", 256'(bus.mem_enable_o), 256'(1));
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    @(posedge clk);
    #1;
    bus.cpu_mem_read_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    access(32'hC20, 1'b0, '0, st, rd);
    chk("rerd_stall", 256'(st), 256'(13));
    chk("rerd_nreq", 256'(reqs.size()), 256'(1));
    chk("rerd_data", 256'(rd), 256'(32'hA000_0C20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
